// File: rtl/sobol_pkg.sv
// Shared definitions for the Sobol sequence generator: DIM encodings and
// the direction-vector construction.
package sobol_pkg;

  localparam int unsigned DIM_VDC    = 0;
  localparam int unsigned DIM_SOBOL2 = 1;
  localparam int unsigned MAX_WIDTH  = 16;

  function automatic int unsigned idx_bits(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // V[0] is the MSB; each later vector is derived from its predecessor.
  function automatic logic [MAX_WIDTH-1:0] dir_vec(input int unsigned width,
                                                  input int unsigned dim,
                                                  input int unsigned k);
    logic [MAX_WIDTH-1:0] v;
    v = MAX_WIDTH'(1) << (width - 1);
    for (int unsigned i = 1; i <= k; i++) begin
      if (dim == DIM_VDC) v = v >> 1;
      else                v = v ^ (v >> 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/sobol_seq_gen_lsz_detect.sv
// Least-significant-zero priority encoder with an all-ones flag.
module lsz_detect
  import sobol_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]             value,
  output logic [idx_bits(WIDTH)-1:0]   index,
  output logic                         all_ones
);

  localparam int unsigned IW = idx_bits(WIDTH);

  // Scan from the top down so the lowest zero bit is the last one written.
  always_comb begin
    index = '0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (!value[i-1]) index = IW'(i - 1);
    end
    all_ones = &value;
  end

endmodule

// File: rtl/sobol_seq_gen.sv
// Gray-code-ordered Sobol / van der Corput sequence generator: one point per
// enabled cycle, idx and rng_out always describe the same point.
module sobol_seq_gen
  import sobol_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIM   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] rng_out,
  output logic             wrap
);

  localparam int unsigned IW = idx_bits(WIDTH);

  logic [WIDTH-1:0] v [WIDTH];
  logic [IW-1:0]    c;
  logic             all_ones;

  always_comb begin
    for (int unsigned k = 0; k < WIDTH; k++) begin
      v[k] = WIDTH'(dir_vec(WIDTH, DIM, k));
    end
  end

  lsz_detect #(
    .WIDTH (WIDTH)
  ) u_lsz (
    .value    (idx),
    .index    (c),
    .all_ones (all_ones)
  );

  // The all-ones step lands on point 0 directly rather than XORing, which
  // keeps the sequence aligned with the index after a wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx     <= '0;
      rng_out <= '0;
      wrap    <= 1'b0;
    end else if (enable) begin
      if (all_ones) begin
        idx     <= '0;
        rng_out <= '0;
        wrap    <= 1'b1;
      end else begin
        idx     <= idx + WIDTH'(1);
        rng_out <= rng_out ^ v[c];
        wrap    <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
